md_unit_ctrl: RTL and testbench

//  Multi-cycle multiply/divide unit with HI/LO registers and its sequencing FSM, in the E stage

---
 rtl/md_unit_ctrl.sv | 163 ++++++++++++++++
 tb/tb_md_unit_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/md_unit_ctrl.sv
// Multi-cycle multiply/divide unit with HI/LO registers, sitting in the E stage
// beside the ALU. A mult/div computes its result when it starts and holds it in
// pending registers. It stays busy for a fixed number of cycles and then commits
// the result to HI/LO.
module md_unit_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic        busy,
   output logic        md_stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6,
      OP_NONE7 = 3'd7
   } md_op_t;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          busy_n;
   logic [31:0]   hi_n, lo_n, pend_hi, pend_lo, pend_hi_n, pend_lo_n;
   md_op_t        op;

   logic [63:0]   prod_s, prod_u;
   logic [31:0]   mag_a, mag_b, div_s, div_u;
   logic [31:0]   q_mag, r_mag, q_s, r_s, q_u, r_u;
   logic          is_md;

   assign op    = md_op_t'(md_op);
   assign is_md = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);

   // Stall F/D whenever a mult/div is in flight or one is being issued now.
   assign md_stall = busy | (start & is_md);

   // Result datapath. Signed division works on magnitudes and then fixes the signs.
   // This makes 0x80000000 / -1 come out as 0x80000000 remainder 0 without a special case.
   // A zero divisor is replaced by 1 here only to keep the divider defined.
   // The zero-divisor result itself is never committed.
   always_comb begin
      prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
      prod_u = {32'b0, src_a} * {32'b0, src_b};
      mag_a  = src_a[31] ? -src_a : src_a;
      mag_b  = src_b[31] ? -src_b : src_b;
      div_s  = (mag_b == '0) ? 32'd1 : mag_b;
      div_u  = (src_b == '0) ? 32'd1 : src_b;
      q_mag  = mag_a / div_s;
      r_mag  = mag_a % div_s;
      q_s    = (src_a[31] ^ src_b[31]) ? -q_mag : q_mag;
      r_s    = src_a[31] ? -r_mag : r_mag;
      q_u    = src_a / div_u;
      r_u    = src_a % div_u;
   end

   // State, counter, HI/LO and pending registers; reset wins over everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         busy    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         busy    <= busy_n;
         hi      <= hi_n;
         lo      <= lo_n;
         pend_hi <= pend_hi_n;
         pend_lo <= pend_lo_n;
      end
   end

   // Next-state logic. Issue happens only from IDLE, and any start seen in RUN is ignored.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      busy_n    = busy;
      hi_n      = hi;
      lo_n      = lo;
      pend_hi_n = pend_hi;
      pend_lo_n = pend_lo;
      case (state)
         S_IDLE: begin
            if (start) begin
               case (op)
                  OP_MULT: begin
                     {pend_hi_n, pend_lo_n} = prod_s;
                     cnt_n   = CW'(MULT_CYCLES - 1);
                     state_n = S_RUN;
                     busy_n  = 1'b1;
                  end
                  OP_MULTU: begin
                     {pend_hi_n, pend_lo_n} = prod_u;
                     cnt_n   = CW'(MULT_CYCLES - 1);
                     state_n = S_RUN;
                     busy_n  = 1'b1;
                  end
                  OP_DIV: begin
                     if (src_b != '0) begin
                        pend_hi_n = r_s;
                        pend_lo_n = q_s;
                     end else begin
                        pend_hi_n = hi;
                        pend_lo_n = lo;
                     end
                     cnt_n   = CW'(DIV_CYCLES - 1);
                     state_n = S_RUN;
                     busy_n  = 1'b1;
                  end
                  OP_DIVU: begin
                     if (src_b != '0) begin
                        pend_hi_n = r_u;
                        pend_lo_n = q_u;
                     end else begin
                        pend_hi_n = hi;
                        pend_lo_n = lo;
                     end
                     cnt_n   = CW'(DIV_CYCLES - 1);
                     state_n = S_RUN;
                     busy_n  = 1'b1;
                  end
                  OP_MTHI: hi_n = src_a;
                  OP_MTLO: lo_n = src_a;
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            if (cnt == '0) begin
               hi_n    = pend_hi;
               lo_n    = pend_lo;
               busy_n  = 1'b0;
               state_n = S_IDLE;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed bench for md_unit_ctrl. A table of single operations checks busy length, stall and HI/LO.
// Hand sequences then cover a start issued during busy and a reset during busy.
module tb_md_unit_ctrl;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [2:0]  md_op;
   logic [31:0] src_a, src_b;
   logic        busy, md_stall;
   logic [31:0] hi, lo;

   int checks   = 0;
   int failures = 0;

   md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start(start), .md_op(md_op),
      .src_a(src_a), .src_b(src_b), .busy(busy), .md_stall(md_stall),
      .hi(hi), .lo(lo)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] a, b, exp_hi, exp_lo;
      int          cyc;
   } vec_t;

   vec_t vecs[14];
   logic [31:0] ref_hi, ref_lo;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Issue one op, count busy cycles, then check HI/LO.
   // Operands are scrambled after issue to show they were captured at start.
   task automatic run_op(input vec_t v);
      int n;
      bit hold_ok;
      start = 1'b1; md_op = v.op; src_a = v.a; src_b = v.b;
      #1 chk({v.name, " stall@start"}, {31'b0, md_stall}, {31'b0, (v.op >= 3'd1 && v.op <= 3'd4)});
      @(posedge clk); #1;
      start = 1'b0; md_op = 3'd0; src_a = $urandom; src_b = $urandom;
      n = 0;
      hold_ok = 1'b1;
      while (busy && n < 50) begin
         n++;
         if (md_stall !== 1'b1 || hi !== ref_hi || lo !== ref_lo) hold_ok = 1'b0;
         @(posedge clk); #1;
      end
      chk({v.name, " busy/hold"}, {31'b0, hold_ok}, 32'd1);
      chk({v.name, " cycles"}, n, v.cyc);
      chk({v.name, " hi"}, hi, v.exp_hi);
      chk({v.name, " lo"}, lo, v.exp_lo);
      ref_hi = v.exp_hi;
      ref_lo = v.exp_lo;
   endtask

   initial begin
      int n;
      vecs[0]  = '{"MULT -1*2",    3'd1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
      vecs[1]  = '{"MULTU ffff*2", 3'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
      vecs[2]  = '{"DIV -7/2",     3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
      vecs[3]  = '{"DIVU 7/2",     3'd4, 32'd7,        32'd2,        32'h00000001, 32'h00000003, 10};
      vecs[4]  = '{"DIV ovf",      3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
      vecs[5]  = '{"MTHI",         3'd5, 32'h1234,     32'hDEAD,     32'h00001234, 32'h80000000, 0};
      vecs[6]  = '{"MTLO",         3'd6, 32'h5678,     32'hBEEF,     32'h00001234, 32'h00005678, 0};
      vecs[7]  = '{"DIV x/0",      3'd3, 32'd99,       32'd0,        32'h00001234, 32'h00005678, 10};
      vecs[8]  = '{"DIVU x/0",     3'd4, 32'd5,        32'd0,        32'h00001234, 32'h00005678, 10};
      vecs[9]  = '{"NONE0",        3'd0, 32'hDEAD,     32'h1,        32'h00001234, 32'h00005678, 0};
      vecs[10] = '{"NONE7",        3'd7, 32'hDEAD,     32'h1,        32'h00001234, 32'h00005678, 0};
      vecs[11] = '{"MULT 3*-4",    3'd1, 32'd3,        32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFF4, 5};
      vecs[12] = '{"DIV 7/-2",     3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
      vecs[13] = '{"MULTU 2^32",   3'd2, 32'h10000,    32'h10000,    32'h00000001, 32'h00000000, 5};

      reset = 1'b1; start = 1'b0; md_op = 3'd0; src_a = '0; src_b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset busy",  {31'b0, busy}, 32'd0);
      chk("reset stall", {31'b0, md_stall}, 32'd0);
      chk("reset hi", hi, 32'd0);
      chk("reset lo", lo, 32'd0);
      reset = 1'b0;
      ref_hi = '0;
      ref_lo = '0;

      for (int i = 0; i < 14; i++) run_op(vecs[i]);

      // A start/MTLO issued in the second busy cycle must be ignored
      start = 1'b1; md_op = 3'd1; src_a = 32'd5; src_b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0; md_op = 3'd0;
      n = 0;
      while (busy && n < 50) begin
         n++;
         chk("ignore stall", {31'b0, md_stall}, 32'd1);
         if (n == 2) begin
            start = 1'b1; md_op = 3'd6; src_a = 32'hAAAA;
         end
         @(posedge clk); #1;
         start = 1'b0; md_op = 3'd0;
      end
      chk("ignore cycles", n, 5);
      chk("ignore hi", hi, 32'd0);
      chk("ignore lo", lo, 32'd35);
      repeat (3) @(posedge clk);
      #1 chk("ignore lo later", lo, 32'd35);

      // Reset in busy cycle 3 of a DIV aborts it with no late commit
      run_op('{"pre MTHI", 3'd5, 32'h1111, 32'd0, 32'h1111, 32'd35,   0});
      run_op('{"pre MTLO", 3'd6, 32'h2222, 32'd0, 32'h1111, 32'h2222, 0});
      start = 1'b1; md_op = 3'd3; src_a = 32'd100; src_b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0; md_op = 3'd0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("abort busy before", {31'b0, busy}, 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort busy", {31'b0, busy}, 32'd0);
      chk("abort hi", hi, 32'd0);
      chk("abort lo", lo, 32'd0);
      repeat (12) @(posedge clk);
      #1;
      chk("abort late busy", {31'b0, busy}, 32'd0);
      chk("abort late hi", hi, 32'd0);
      chk("abort late lo", lo, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
